// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute/memory/commit control FSM for an RV32I core.
// Traps on request timeout or illegal opcode; counts retired instructions.
module instr_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             halt,
    input  logic             i_ack,
    input  logic [31:0]      instr_in,
    input  logic             d_ack,
    input  logic             branch_taken,
    output logic             i_req,
    output logic             d_req,
    output logic             d_we,
    output logic [31:0]      instr,
    output logic             pc_en,
    output logic             pc_load,
    output logic             reg_we,
    output logic [CNT_W-1:0] retired,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ERR_FETCH = 2'b01;
    localparam logic [1:0] ERR_DATA  = 2'b10;
    localparam logic [1:0] ERR_ILL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_COMMIT,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic              tk_q, tk_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [6:0] opcode;
    assign opcode = instr_q[6:0];

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            tk_q       <= 1'b0;
            wait_q     <= '0;
            retired_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            tk_q       <= tk_d;
            wait_q     <= wait_d;
            retired_q  <= retired_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        tk_d       = tk_q;
        retired_d  = retired_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE: begin
                if (!halt) state_d = S_FETCH;
            end
            S_FETCH: begin
                // ack wins over a coinciding timeout
                if (i_ack) begin
                    instr_d = instr_in;
                    state_d = S_EXEC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    err_code_d = ERR_FETCH;
                end
            end
            S_EXEC: begin
                tk_d = branch_taken;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_ALU, OP_ALUI, OP_BRANCH, OP_JAL, OP_JALR,
                    OP_LUI, OP_AUIPC, OP_SYSTEM: state_d = S_COMMIT;
                    default: begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_ILL;
                    end
                endcase
            end
            S_MEM: begin
                if (d_ack) begin
                    state_d = S_COMMIT;
                end else if (wait_q == WAIT_LAST) begin
                    state_d    = S_ERROR;
                    err_d      = 1'b1;
                    err_code_d = ERR_DATA;
                end
            end
            S_COMMIT: begin
                retired_d = retired_q + 1'b1;
                state_d   = halt ? S_IDLE : S_FETCH;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wait counter restarts whenever FETCH or MEM is entered, counts while the state holds
    always_comb begin
        wait_d = '0;
        if ((state_q == S_FETCH && state_d == S_FETCH) ||
            (state_q == S_MEM && state_d == S_MEM)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_comb begin
        i_req   = (state_q == S_FETCH);
        d_req   = (state_q == S_MEM);
        d_we    = (state_q == S_MEM) && (opcode == OP_STORE);
        pc_en   = (state_q == S_COMMIT);
        pc_load = (state_q == S_COMMIT) &&
                  ((opcode == OP_JAL) || (opcode == OP_JALR) ||
                   ((opcode == OP_BRANCH) && tk_q));
        reg_we  = (state_q == S_COMMIT) &&
                  !((opcode == OP_STORE) || (opcode == OP_BRANCH) ||
                    (opcode == OP_SYSTEM));
    end

    assign instr    = instr_q;
    assign retired  = retired_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ALU, branch, load/store, timeouts,
// illegal opcode, halt and asynchronous reset.
module tb_instr_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] BEQ  = 32'h0042_0263;
    localparam logic [31:0] LW   = 32'h0000_a103;
    localparam logic [31:0] SW   = 32'h0020_a023;
    localparam logic [31:0] ILL  = 32'h0000_007F;

    logic             clk = 1'b0;
    logic             nRst;
    logic             halt;
    logic             i_ack;
    logic [31:0]      instr_in;
    logic             d_ack;
    logic             branch_taken;
    logic             i_req;
    logic             d_req;
    logic             d_we;
    logic [31:0]      instr;
    logic             pc_en;
    logic             pc_load;
    logic             reg_we;
    logic [CNT_W-1:0] retired;
    logic             err;
    logic [1:0]       err_code;

    int n_tests = 0;
    int n_fail  = 0;

    instr_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .nRst(nRst), .halt(halt), .i_ack(i_ack), .instr_in(instr_in),
        .d_ack(d_ack), .branch_taken(branch_taken), .i_req(i_req), .d_req(d_req),
        .d_we(d_we), .instr(instr), .pc_en(pc_en), .pc_load(pc_load),
        .reg_we(reg_we), .retired(retired), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".i_req"},    i_req,    1'b0);
        check({tag, ".d_req"},    d_req,    1'b0);
        check({tag, ".pc_en"},    pc_en,    1'b0);
        check({tag, ".reg_we"},   reg_we,   1'b0);
        check({tag, ".instr"},    instr,    32'h0);
        check({tag, ".retired"},  retired,  '0);
        check({tag, ".err"},      err,      1'b0);
        check({tag, ".err_code"}, err_code, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRst = 1'b0; halt = 1'b1; i_ack = 1'b0; instr_in = 32'h0;
        d_ack = 1'b0; branch_taken = 1'b0;
        step(2);
        check_reset_vals("rst");

        // halt held in IDLE: no fetch
        nRst = 1'b1;
        step(2);
        check("idle_halt.i_req", i_req, 1'b0);

        // 1. back-to-back ADDI with zero-wait acks
        halt = 1'b0; i_ack = 1'b1; instr_in = ADDI;
        step();
        check("addi.i_req", i_req, 1'b1);
        step();
        check("addi.exec_i_req", i_req, 1'b0);
        check("addi.instr", instr, ADDI);
        step();
        check("addi.pc_en", pc_en, 1'b1);
        check("addi.reg_we", reg_we, 1'b1);
        check("addi.pc_load", pc_load, 1'b0);
        step();
        check("addi.retired1", retired, 1);
        check("addi.fetch_pc_en", pc_en, 1'b0);
        step(2);
        check("addi.pc_en2", pc_en, 1'b1);
        step();
        check("addi.retired2", retired, 2);

        // 2. BEQ taken, then not taken
        instr_in = BEQ; branch_taken = 1'b1;
        step();
        step();
        check("beq_t.pc_en", pc_en, 1'b1);
        check("beq_t.pc_load", pc_load, 1'b1);
        check("beq_t.reg_we", reg_we, 1'b0);
        branch_taken = 1'b0;
        step(3);
        check("beq_n.pc_en", pc_en, 1'b1);
        check("beq_n.pc_load", pc_load, 1'b0);
        check("beq_n.reg_we", reg_we, 1'b0);
        step();
        check("beq.retired", retired, 4);

        // 3. LW with d_ack on the 4th MEM cycle, then SW with zero wait
        instr_in = LW;
        step();
        step();
        check("lw.d_req1", d_req, 1'b1);
        check("lw.d_we", d_we, 1'b0);
        step(2);
        check("lw.d_req3", d_req, 1'b1);
        step();
        check("lw.d_req4", d_req, 1'b1);
        d_ack = 1'b1;
        step();
        d_ack = 1'b0;
        check("lw.commit_d_req", d_req, 1'b0);
        check("lw.reg_we", reg_we, 1'b1);
        check("lw.pc_en", pc_en, 1'b1);
        step();
        check("lw.retired", retired, 5);
        instr_in = SW;
        step();
        d_ack = 1'b1;
        step();
        check("sw.d_req", d_req, 1'b1);
        check("sw.d_we", d_we, 1'b1);
        step();
        d_ack = 1'b0;
        check("sw.reg_we", reg_we, 1'b0);
        check("sw.pc_en", pc_en, 1'b1);
        step();
        check("sw.retired", retired, 6);

        // 4. ack arriving on the 16th FETCH cycle does not trap
        instr_in = ADDI; i_ack = 1'b0;
        step(15);
        check("to_edge.i_req", i_req, 1'b1);
        i_ack = 1'b1;
        step();
        check("to_edge.err", err, 1'b0);
        check("to_edge.instr", instr, ADDI);
        step(2);
        check("to_edge.retired", retired, 7);

        // 4. no ack for 16 FETCH cycles traps
        i_ack = 1'b0;
        step(15);
        check("to_fetch.i_req16", i_req, 1'b1);
        check("to_fetch.err_pre", err, 1'b0);
        step();
        check("to_fetch.i_req", i_req, 1'b0);
        check("to_fetch.err", err, 1'b1);
        check("to_fetch.err_code", err_code, 2'b01);
        i_ack = 1'b1;
        step(3);
        check("to_fetch.stuck_i_req", i_req, 1'b0);
        check("to_fetch.stuck_err", err, 1'b1);

        #2 nRst = 1'b0;
        #1;
        check_reset_vals("rst_err");

        // 5. illegal opcode after one retired ADDI
        #2 nRst = 1'b1;
        halt = 1'b0; i_ack = 1'b1; instr_in = ADDI;
        step(3);
        instr_in = ILL;
        step();
        check("ill.retired_pre", retired, 1);
        step(2);
        check("ill.err", err, 1'b1);
        check("ill.err_code", err_code, 2'b11);
        check("ill.retired", retired, 1);
        check("ill.pc_en", pc_en, 1'b0);

        // 6. halt raised mid-FETCH
        #2 nRst = 1'b0;
        #2 nRst = 1'b1;
        halt = 1'b0; i_ack = 1'b0; instr_in = ADDI;
        step();
        check("halt.fetch", i_req, 1'b1);
        halt = 1'b1;
        step();
        check("halt.fetch_held", i_req, 1'b1);
        i_ack = 1'b1;
        step(2);
        check("halt.commit", pc_en, 1'b1);
        step();
        check("halt.idle_i_req", i_req, 1'b0);
        step();
        check("halt.idle2_i_req", i_req, 1'b0);
        check("halt.retired", retired, 1);
        halt = 1'b0;
        step();
        check("halt.resume", i_req, 1'b1);

        // async reset during MEM
        instr_in = LW; d_ack = 1'b0;
        step(2);
        check("mem_rst.d_req_pre", d_req, 1'b1);
        #2 nRst = 1'b0;
        #1;
        check("mem_rst.d_req", d_req, 1'b0);
        check_reset_vals("mem_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
